// File: rtl/bvurem_ic_skolem_seq_pkg.sv
// ----------------------------------------------------------------------------
// bvic_pkg
// Shared types and the invertibility-condition / witness function for the
// unsigned-remainder Skolem generator. The function is written against a
// fixed maximum width so that any operand width up to IW_MAX can reuse it.
// Callers zero-extend their operands and take the low bits of the witness.
//   ic_witness(s, t, mode, w) returns {ic, x[IW_MAX-1:0]}
// ----------------------------------------------------------------------------
package bvic_pkg;

    localparam int unsigned IW_MAX = 32;

    typedef enum logic {
        MODE_UGT = 1'b0,
        MODE_ULT = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Invertibility condition and witness for (x urem s) >u t / <u t at width w.
    function automatic logic [IW_MAX:0] ic_witness(
        input logic [IW_MAX-1:0] s,
        input logic [IW_MAX-1:0] t,
        input mode_e             mode,
        input int unsigned       w
    );
        logic [IW_MAX-1:0] mask_s;
        logic              ic_s;
        logic [IW_MAX-1:0] x_s;
        if (w >= IW_MAX) begin
            mask_s = {IW_MAX{1'b1}};
        end else begin
            mask_s = (32'd1 << w) - 32'd1;
        end
        ic_s = 1'b0;
        x_s  = {IW_MAX{1'b0}};
        case (mode)
            MODE_UGT: begin
                if (s == {IW_MAX{1'b0}}) begin
                    // urem by zero returns x itself, so any x above t works
                    ic_s = (t != mask_s);
                    x_s  = ic_s ? ((t + 32'd1) & mask_s) : {IW_MAX{1'b0}};
                end else begin
                    // the largest remainder reachable is s-1
                    ic_s = (t < (s - 32'd1));
                    x_s  = ic_s ? (s - 32'd1) : {IW_MAX{1'b0}};
                end
            end
            MODE_ULT: begin
                // remainder 0 (x = 0) is below every nonzero t
                ic_s = (t != {IW_MAX{1'b0}});
                x_s  = {IW_MAX{1'b0}};
            end
            default: begin
                ic_s = 1'b0;
                x_s  = {IW_MAX{1'b0}};
            end
        endcase
        return {ic_s, x_s};
    endfunction

endpackage

// File: rtl/bvurem_ic_skolem_seq_urem_serial.sv
// ----------------------------------------------------------------------------
// urem_serial
// Restoring serial remainder unit: one dividend bit per cycle, MSB first.
// A start pulse clears the partial remainder and loads the bit counter; W
// cycles later rem holds x urem s (x urem 0 = x falls out naturally because
// subtracting zero always succeeds). x and s must stay stable while busy.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load and begin (ignored while busy)
//   x, s       dividend, divisor
//   busy       division in progress
//   done       high during the final step cycle (rem updates at its end)
//   rem        latched remainder
//   rem_nxt    remainder being produced this cycle, valid when done = 1
// ----------------------------------------------------------------------------
module urem_serial
    import bvic_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] s,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rem,
    output logic [W-1:0] rem_nxt
);

    localparam int unsigned CW = ($clog2(W) < 1) ? 1 : $clog2(W);

    logic [W:0]    r_r;
    logic [CW-1:0] cnt_r;
    logic          busy_r;
    logic [W-1:0]  rem_r;

    logic [W:0]    r_shift_s;
    logic [W:0]    r_step_s;
    logic          done_s;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        r_shift_s = {r_r[W-1:0], x[cnt_r]};
        if (r_shift_s >= {1'b0, s}) begin
            r_step_s = r_shift_s - {1'b0, s};
        end else begin
            r_step_s = r_shift_s;
        end
        done_s = busy_r && (cnt_r == {CW{1'b0}});
    end

    // Partial remainder, bit counter, busy flag and latched result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r    <= {(W+1){1'b0}};
            cnt_r  <= {CW{1'b0}};
            busy_r <= 1'b0;
            rem_r  <= {W{1'b0}};
        end else if (start && !busy_r) begin
            r_r    <= {(W+1){1'b0}};
            cnt_r  <= CW'(W-1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            r_r <= r_step_s;
            if (cnt_r == {CW{1'b0}}) begin
                busy_r <= 1'b0;
                rem_r  <= r_step_s[W-1:0];
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end
    end

    assign busy    = busy_r;
    assign done    = done_s;
    assign rem     = rem_r;
    assign rem_nxt = r_step_s[W-1:0];

endmodule

// File: rtl/bvurem_ic_skolem_seq.sv
// ----------------------------------------------------------------------------
// bvurem_ic_skolem_seq
// Skolem witness generator for (x urem s) >u t (mode 0) and <u t (mode 1).
// On acceptance it registers the invertibility condition ic and witness x,
// then replays x urem s through a serial divider and flags whether the
// recomputed remainder agrees with ic.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake carrying s, t, mode
//   out_valid/out_ready result handshake carrying ic, x, rem, check_ok
// Latency: out_valid rises W+1 cycles after the acceptance edge; the first
// DIV cycle launches the divider, the next W cycles step it.
// ----------------------------------------------------------------------------
module bvurem_ic_skolem_seq
    import bvic_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] s,
    input  logic [W-1:0] t,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ic,
    output logic [W-1:0] x,
    output logic [W-1:0] rem,
    output logic         check_ok
);

    state_e        state_r;
    state_e        state_nxt_s;

    logic [W-1:0]  s_r;
    logic [W-1:0]  t_r;
    mode_e         mode_r;
    logic          ic_r;
    logic [W-1:0]  x_r;
    logic          check_ok_r;
    logic          in_ready_r;
    logic          out_valid_r;

    logic [IW_MAX-1:0] s_ext_s;
    logic [IW_MAX-1:0] t_ext_s;
    logic [IW_MAX:0]   icw_s;
    logic              ic_s;
    logic [W-1:0]      x_s;
    logic              unused_icw_s;

    logic          accept_s;
    logic          start_s;
    logic          div_busy_s;
    logic          div_done_s;
    logic [W-1:0]  div_rem_s;
    logic [W-1:0]  div_rem_nxt_s;
    logic          cmp_s;

    // Condition and witness for the operands currently on the input port.
    always_comb begin
        s_ext_s          = {IW_MAX{1'b0}};
        t_ext_s          = {IW_MAX{1'b0}};
        s_ext_s[W-1:0]   = s;
        t_ext_s[W-1:0]   = t;
        icw_s            = ic_witness(s_ext_s, t_ext_s, mode_e'(mode), W);
        ic_s             = icw_s[IW_MAX];
        x_s              = icw_s[W-1:0];
        unused_icw_s     = ^icw_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt_s = S_DIV;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_DIV: begin
                if (div_done_s) begin
                    state_nxt_s = S_DONE;
                end else begin
                    state_nxt_s = S_DIV;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DONE;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM control outputs: request capture and divider launch.
    always_comb begin
        accept_s = 1'b0;
        start_s  = 1'b0;
        case (state_r)
            S_IDLE:  accept_s = in_valid;
            // busy drops on the final step edge, by which time the state is DONE
            S_DIV:   start_s  = !div_busy_s;
            S_DONE:  start_s  = 1'b0;
            default: begin
                accept_s = 1'b0;
                start_s  = 1'b0;
            end
        endcase
    end

    // Handshake flags registered from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == S_IDLE);
            out_valid_r <= (state_nxt_s == S_DONE);
        end
    end

    // Request capture: operands, condition and witness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r    <= {W{1'b0}};
            t_r    <= {W{1'b0}};
            mode_r <= MODE_UGT;
            ic_r   <= 1'b0;
            x_r    <= {W{1'b0}};
        end else if (accept_s) begin
            s_r    <= s;
            t_r    <= t;
            mode_r <= mode_e'(mode);
            ic_r   <= ic_s;
            x_r    <= x_s;
        end
    end

    urem_serial #(
        .W (W)
    ) u_urem (
        .clk     (clk),
        .rst     (rst),
        .start   (start_s),
        .x       (x_r),
        .s       (s_r),
        .busy    (div_busy_s),
        .done    (div_done_s),
        .rem     (div_rem_s),
        .rem_nxt (div_rem_nxt_s)
    );

    // Requested relation evaluated on the remainder the divider is finishing.
    always_comb begin
        if (mode_r == MODE_ULT) begin
            cmp_s = (div_rem_nxt_s < t_r);
        end else begin
            cmp_s = (div_rem_nxt_s > t_r);
        end
    end

    // Self-check flag, latched together with the final remainder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_ok_r <= 1'b0;
        end else if (div_done_s) begin
            check_ok_r <= (cmp_s == ic_r);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign ic        = ic_r;
    assign x         = x_r;
    assign rem       = div_rem_s;
    assign check_ok  = check_ok_r;

endmodule

// File: tb/tb_bvurem_ic_skolem_seq.sv
// Directed and exhaustive bench for bvurem_ic_skolem_seq at W = 4.
module tb_bvurem_ic_skolem_seq;
    import bvic_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] s;
    logic [3:0] t;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic       ic;
    logic [3:0] x;
    logic [3:0] rem;
    logic       check_ok;

    int checks   = 0;
    int failures = 0;

    bvurem_ic_skolem_seq #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s         (s),
        .t         (t),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ic        (ic),
        .x         (x),
        .rem       (rem),
        .check_ok  (check_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] sv, input logic [3:0] tv, input logic mv);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        s        = sv;
        t        = tv;
        mode     = mv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic chk_res(input string tag, input logic eic, input logic [3:0] ex,
                           input logic [3:0] erem, input logic eck);
        chk({tag, "_ic"},       {31'd0, ic},       {31'd0, eic});
        chk({tag, "_x"},        {28'd0, x},        {28'd0, ex});
        chk({tag, "_rem"},      {28'd0, rem},      {28'd0, erem});
        chk({tag, "_check_ok"}, {31'd0, check_ok}, {31'd0, eck});
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [32:0] ref_w;
        logic [3:0]  ex;
        logic [3:0]  erem;
        logic [3:0]  rx;
        logic        found;
        logic        rdy;
        int          k;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        s         = 4'd0;
        t         = 4'd0;
        mode      = 1'b0;
        #12;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk_res("reset", 1'b0, 4'd0, 4'd0, 1'b0);
        rst = 1'b0;
        tick();

        // UGT s=5 t=3: witness 4, latency W+1
        send(4'd5, 4'd3, 1'b0);
        wait_valid(lat);
        chk("lat_ugt_s5_t3", lat, 32'd5);
        chk_res("ugt_s5_t3", 1'b1, 4'd4, 4'd4, 1'b1);
        release_out();
        chk("in_ready_after_done", {31'd0, in_ready},  32'd1);
        chk("out_valid_after_done", {31'd0, out_valid}, 32'd0);

        send(4'd5, 4'd4, 1'b0);
        wait_valid(lat);
        chk_res("ugt_s5_t4", 1'b0, 4'd0, 4'd0, 1'b1);
        release_out();

        send(4'd0, 4'd14, 1'b0);
        wait_valid(lat);
        chk_res("ugt_s0_t14", 1'b1, 4'd15, 4'd15, 1'b1);
        release_out();

        send(4'd0, 4'd15, 1'b0);
        wait_valid(lat);
        chk_res("ugt_s0_t15", 1'b0, 4'd0, 4'd0, 1'b1);
        release_out();

        send(4'd3, 4'd7, 1'b1);
        wait_valid(lat);
        chk_res("ult_s3_t7", 1'b1, 4'd0, 4'd0, 1'b1);
        release_out();

        send(4'd3, 4'd0, 1'b1);
        wait_valid(lat);
        chk_res("ult_s3_t0", 1'b0, 4'd0, 4'd0, 1'b1);
        release_out();

        // in_valid pulse during DIV must be ignored; then 10 cycles of backpressure
        send(4'd5, 4'd3, 1'b0);
        chk("in_ready_in_div", {31'd0, in_ready}, 32'd0);
        s        = 4'd0;
        t        = 4'd0;
        mode     = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk_res("bp", 1'b1, 4'd4, 4'd4, 1'b1);
            tick();
        end
        release_out();
        tick();
        tick();
        chk("no_phantom_request", {31'd0, out_valid}, 32'd0);
        chk("idle_in_ready",      {31'd0, in_ready},  32'd1);

        // reset in the second DIV cycle aborts immediately
        send(4'd0, 4'd14, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_in_ready",  {31'd0, in_ready},  32'd1);
        chk_res("rst_mid", 1'b0, 4'd0, 4'd0, 1'b0);
        #2;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_no_partial", {31'd0, out_valid}, 32'd0);
        send(4'd0, 4'd14, 1'b0);
        wait_valid(lat);
        chk("lat_after_rst", lat, 32'd5);
        chk_res("after_rst", 1'b1, 4'd15, 4'd15, 1'b1);
        release_out();

        // exhaustive sweep with random out_ready
        for (int m = 0; m < 2; m++) begin
            for (int sv = 0; sv < 16; sv++) begin
                for (int tv = 0; tv < 16; tv++) begin
                    send(4'(sv), 4'(tv), 1'(m));
                    wait_valid(lat);
                    ref_w = ic_witness(32'(sv), 32'(tv), mode_e'(m), 4);
                    ex    = ref_w[3:0];
                    erem  = (sv == 0) ? ex : 4'(32'(ex) % 32'(sv));
                    chk_res("sweep", ref_w[32], ex, erem, 1'b1);
                    // brute-force existence of any x satisfying the relation
                    found = 1'b0;
                    for (int xx = 0; xx < 16; xx++) begin
                        rx = (sv == 0) ? 4'(xx) : 4'(xx % sv);
                        if ((m == 1) ? (32'(rx) < 32'(tv)) : (32'(rx) > 32'(tv))) begin
                            found = 1'b1;
                        end
                    end
                    chk("sweep_ic_bruteforce", {31'd0, ic}, {31'd0, found});
                    k = 0;
                    do begin
                        rdy       = 1'($urandom_range(0, 1));
                        out_ready = rdy;
                        tick();
                        k++;
                        if (!rdy) begin
                            chk("sweep_hold_valid", {31'd0, out_valid}, 32'd1);
                        end
                    end while (!rdy && k < 20);
                    if (!rdy) begin
                        out_ready = 1'b1;
                        tick();
                    end
                    out_ready = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
